// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if : memory port, redirect and decode-side signals of fetch_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        pc_load_en;
  logic [15:0] pc_load_val;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        stall;

  modport master (
    output mem_addr,
    input  mem_data,
    input  pc_load_en,
    input  pc_load_val,
    output instr,
    output instr_valid,
    output pc,
    output stall
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output pc_load_en,
    output pc_load_val,
    input  instr,
    input  instr_valid,
    input  pc,
    input  stall
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : byte-serial instruction fetch, assembles 2/3/4-byte words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fetch_stage_if.master bus
);

  localparam logic [2:0] S_W0   = 3'd0;
  localparam logic [2:0] S_W1   = 3'd1;
  localparam logic [2:0] S_W2   = 3'd2;
  localparam logic [2:0] S_W3   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] C_LEN2 = 3'd2;
  localparam logic [2:0] C_LEN3 = 3'd3;
  localparam logic [2:0] C_LEN4 = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  len_q, len_d;

  // Instruction length in bytes, taken from the opcode byte alone.
  function automatic logic [2:0] len_of(input logic [7:0] op);
    logic [2:0] l;
    if (op <= 8'h25)      l = C_LEN3;
    else if (op <= 8'h2D) l = C_LEN2;
    else if (op <= 8'h31) l = C_LEN3;
    else if (op <= 8'h35) l = C_LEN2;
    else if (op <= 8'h3F) l = C_LEN4;
    else                  l = C_LEN2;
    return l;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    len_d   = len_q;
    if (bus.pc_load_en) begin
      // Redirect discards any partial fetch but leaves instr untouched.
      pc_d    = bus.pc_load_val;
      state_d = S_W0;
    end else begin
      case (state_q)
        S_W0: begin
          instr_d = {bus.mem_data, 24'h0};
          len_d   = len_of(bus.mem_data);
          pc_d    = pc_q + 16'd1;
          state_d = S_W1;
        end
        S_W1: begin
          instr_d[23:16] = bus.mem_data;
          pc_d           = pc_q + 16'd1;
          state_d        = (len_q == C_LEN2) ? S_DONE : S_W2;
        end
        S_W2: begin
          instr_d[15:8] = bus.mem_data;
          pc_d          = pc_q + 16'd1;
          state_d       = (len_q == C_LEN3) ? S_DONE : S_W3;
        end
        S_W3: begin
          instr_d[7:0] = bus.mem_data;
          pc_d         = pc_q + 16'd1;
          state_d      = S_DONE;
        end
        S_DONE:  state_d = S_W0;
        default: state_d = S_W0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_W0;
      pc_q    <= 16'h0000;
      instr_q <= 32'h0000_0000;
      len_q   <= C_LEN2;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      len_q   <= len_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == S_DONE);
  assign bus.stall       = (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed scoreboard bench for fetch_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
    int          len;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [7:0] mem [0:65535];
  exp_t sb [$];
  int n_asserts = 0;
  int n_fail    = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mem_data = mem[bus.mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Load an instruction image and queue the word decode should see for it.
  task automatic put_instr(input logic [15:0] addr, input int n,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [31:0] exp_instr);
    exp_t e;
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < n; i++) mem[addr + 16'(i)] = b[i];
    e.instr = exp_instr;
    e.pc    = addr + 16'(n);
    e.len   = n;
    sb.push_back(e);
  endtask

  // Runs from W0 until instr_valid (bounded), then checks against the scoreboard.
  task automatic do_fetch(input string tag);
    exp_t e;
    int   k;
    bit   seen;
    k = 0;
    seen = 1'b0;
    e.instr = 32'hx; e.pc = 16'hx; e.len = 0;
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(posedge clk); #1;
      k = i;
      if (bus.instr_valid) seen = 1'b1;
      else check({tag, "-stall_busy"}, 32'(bus.stall), 32'd1);
    end
    check({tag, "-latency"}, 32'(k), 32'(e.len));
    check({tag, "-valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "-stall_done"}, 32'(bus.stall), 32'd0);
    check({tag, "-instr"}, bus.instr, e.instr);
    check({tag, "-pc"}, 32'(bus.pc), 32'(e.pc));
    check({tag, "-mem_addr"}, 32'(bus.mem_addr), 32'(e.pc));
  endtask

  task automatic adv_w0(input string tag);
    @(posedge clk); #1;
    check({tag, "-valid_fall"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "-stall_rise"}, 32'(bus.stall), 32'd1);
  endtask

  task automatic redirect(input string tag, input logic [15:0] target, input logic [31:0] held);
    bus.pc_load_en  = 1'b1;
    bus.pc_load_val = target;
    @(posedge clk); #1;
    bus.pc_load_en  = 1'b0;
    check({tag, "-pc"}, 32'(bus.pc), 32'(target));
    check({tag, "-valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "-instr_held"}, bus.instr, held);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    rst_n           = 1'b1;
    bus.pc_load_en  = 1'b0;
    bus.pc_load_val = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset-pc", 32'(bus.pc), 32'h0);
    check("reset-mem_addr", 32'(bus.mem_addr), 32'h0);
    check("reset-valid", 32'(bus.instr_valid), 32'd0);
    check("reset-stall", 32'(bus.stall), 32'd1);
    check("reset-instr", bus.instr, 32'h0);

    put_instr(16'h0000, 3, 8'h00, 8'h0C, 8'h12, 8'h00, 32'h000C1200);
    rst_n = 1'b1;
    do_fetch("add");   adv_w0("add");
    put_instr(16'h0003, 2, 8'h26, 8'h14, 8'h00, 8'h00, 32'h26140000);
    do_fetch("jmp");   adv_w0("jmp");
    put_instr(16'h0005, 4, 8'h36, 8'h12, 8'h30, 8'h40, 32'h36123040);
    do_fetch("sle");   adv_w0("sle");
    put_instr(16'h0009, 3, 8'h2E, 8'h1A, 8'h2B, 8'h00, 32'h2E1A2B00);
    do_fetch("lmar");  adv_w0("lmar");
    put_instr(16'h000C, 2, 8'h32, 8'h00, 8'h00, 8'h00, 32'h32000000);
    do_fetch("imar");  adv_w0("imar");

    redirect("redir_w0", 16'h0080, 32'h32000000);
    put_instr(16'h0080, 3, 8'h08, 8'h04, 8'h23, 8'h00, 32'h08042300);
    do_fetch("xor");   adv_w0("xor");
    put_instr(16'h0083, 2, 8'h32, 8'h55, 8'h00, 8'h00, 32'h32550000);
    do_fetch("imar2"); adv_w0("imar2");
    put_instr(16'h0085, 2, 8'h26, 8'h10, 8'h00, 8'h00, 32'h26100000);
    do_fetch("jmp2");  adv_w0("jmp2");
    put_instr(16'h0087, 2, 8'h27, 8'h14, 8'h00, 8'h00, 32'h27140000);
    do_fetch("jmz");   adv_w0("jmz");
    put_instr(16'h0089, 2, 8'h28, 8'h18, 8'h00, 8'h00, 32'h28180000);
    do_fetch("jmn");   adv_w0("jmn");

    // Opcodes on either side of every length boundary.
    put_instr(16'h008B, 3, 8'h25, 8'h01, 8'h02, 8'h00, 32'h25010200);
    do_fetch("op25");  adv_w0("op25");
    put_instr(16'h008E, 2, 8'h2D, 8'h03, 8'h00, 8'h00, 32'h2D030000);
    do_fetch("op2d");  adv_w0("op2d");
    put_instr(16'h0090, 3, 8'h31, 8'h04, 8'h05, 8'h00, 32'h31040500);
    do_fetch("op31");  adv_w0("op31");
    put_instr(16'h0093, 2, 8'h35, 8'h06, 8'h00, 8'h00, 32'h35060000);
    do_fetch("op35");  adv_w0("op35");
    put_instr(16'h0095, 4, 8'h3F, 8'h01, 8'h02, 8'h03, 32'h3F010203);
    do_fetch("op3f");  adv_w0("op3f");
    put_instr(16'h0099, 2, 8'h40, 8'h07, 8'h00, 8'h00, 32'h40070000);
    do_fetch("op40");  adv_w0("op40");
    put_instr(16'h009B, 2, 8'hFF, 8'h08, 8'h00, 8'h00, 32'hFF080000);
    do_fetch("opff");

    redirect("redir_done", 16'hFFFE, 32'hFF080000);
    put_instr(16'hFFFE, 2, 8'h26, 8'h01, 8'h00, 8'h00, 32'h26010000);
    do_fetch("wrap");  adv_w0("wrap");

    // Redirect from W1: the byte at pc 0x0001 must not land in instr.
    @(posedge clk); #1;
    check("mid-w0_instr", bus.instr, 32'h00000000);
    check("mid-w0_pc", 32'(bus.pc), 32'h0001);
    redirect("redir_w1", 16'h0085, 32'h00000000);
    put_instr(16'h0085, 2, 8'h26, 8'h10, 8'h00, 8'h00, 32'h26100000);
    do_fetch("jmp3");  adv_w0("jmp3");

    redirect("redir_alu", 16'h0080, 32'h26100000);
    @(posedge clk); #1;
    check("pre_rst-instr", bus.instr, 32'h08000000);
    check("pre_rst-pc", 32'(bus.pc), 32'h0081);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst-pc", 32'(bus.pc), 32'h0);
    check("async_rst-mem_addr", 32'(bus.mem_addr), 32'h0);
    check("async_rst-valid", 32'(bus.instr_valid), 32'd0);
    check("async_rst-stall", 32'(bus.stall), 32'd1);
    check("async_rst-instr", bus.instr, 32'h0);
    @(posedge clk); #1;
    put_instr(16'h0000, 3, 8'h00, 8'h0C, 8'h12, 8'h00, 32'h000C1200);
    rst_n = 1'b1;
    do_fetch("add_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
